// File: rtl/ad_decimator_pkg.sv
// Shared constants and helpers for the averaging decimator.
// Widths follow the AD7606 sample format and the 2^k averaging depth.
package ad_decimator_pkg;

    localparam int AD_DATA_NBIT     = 16;
    localparam int AD_CHN_NUM       = 8;
    localparam int AD_DEC_MAX_LOG2  = 8;
    localparam int AD_ACC_NBIT      = AD_DATA_NBIT + AD_DEC_MAX_LOG2;
    localparam int AD_DEC_LOG2_NBIT = 4;
    localparam int AD_CNT_NBIT      = 9;
    localparam int AD_BLK_NBIT      = 16;

    // Requested exponents above the supported depth fall back to the maximum.
    function automatic logic [AD_DEC_LOG2_NBIT-1:0] clamp_log2(
        input logic [AD_DEC_LOG2_NBIT-1:0] req,
        input int                          max_log2
    );
        if (int'(req) > max_log2) begin
            return AD_DEC_LOG2_NBIT'(max_log2);
        end
        return req;
    endfunction

endpackage

// File: rtl/ad_dec_lane.sv
// One channel of the decimator: accumulate, round, shift, hold.
// Strobes and the exponent come from the shared control in the parent.
module ad_dec_lane
    import ad_decimator_pkg::*;
#(
    parameter int DATA_NBIT = AD_DATA_NBIT,
    parameter int MAX_LOG2  = AD_DEC_MAX_LOG2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        load,
    input  logic                        add,
    input  logic                        done,
    input  logic [AD_DEC_LOG2_NBIT-1:0] k,
    input  logic [DATA_NBIT-1:0]        din,
    output logic [DATA_NBIT-1:0]        dout
);

    localparam int ACC_NBIT = DATA_NBIT + MAX_LOG2;

    logic signed [ACC_NBIT-1:0] acc_q, acc_d;
    logic signed [ACC_NBIT-1:0] din_ext;
    logic signed [ACC_NBIT-1:0] sum;
    logic signed [ACC_NBIT-1:0] rnd;
    logic signed [ACC_NBIT-1:0] rsum;
    logic [DATA_NBIT-1:0]       dout_q, dout_d;

    // Running sum including the current sample, then round-half-up average.
    always_comb begin
        din_ext = {{MAX_LOG2{din[DATA_NBIT-1]}}, din};
        sum     = load ? din_ext : acc_q + din_ext;
        rnd     = '0;
        if (k != '0) begin
            rnd = ACC_NBIT'(1) << (k - AD_DEC_LOG2_NBIT'(1));
        end
        rsum   = sum + rnd;
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load || add) begin
            acc_d = sum;
        end
        dout_d = dout_q;
        if (done) begin
            dout_d = DATA_NBIT'(rsum >>> k);
        end
    end

    // Accumulator and held output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ad_decimator.sv
// Averaging decimator between the AD7606 controller and the channel cache.
// Emits one rounded 2^k average per channel per block of conversions.
module ad_decimator
    import ad_decimator_pkg::*;
#(
    parameter int DATA_NBIT = AD_DATA_NBIT,
    parameter int CHN_NUM   = AD_CHN_NUM,
    parameter int MAX_LOG2  = AD_DEC_MAX_LOG2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AD_DEC_LOG2_NBIT-1:0]   dec_log2,
    input  logic                          clr,
    input  logic                          in_vd,
    input  logic [CHN_NUM*DATA_NBIT-1:0]  in_data,
    output logic                          out_vd,
    output logic [CHN_NUM*DATA_NBIT-1:0]  out_data,
    output logic [AD_BLK_NBIT-1:0]        blk_cnt
);

    logic [AD_CNT_NBIT-1:0]      cnt_q, cnt_d;
    logic [AD_DEC_LOG2_NBIT-1:0] k_lat_q, k_lat_d;
    logic [AD_DEC_LOG2_NBIT-1:0] k_cur;
    logic [AD_CNT_NBIT-1:0]      last_cnt;
    logic                        take;
    logic                        blk_start;
    logic                        acc_load;
    logic                        acc_add;
    logic                        blk_done;
    logic                        out_vd_q, out_vd_d;
    logic [AD_BLK_NBIT-1:0]      blk_cnt_q, blk_cnt_d;

    // Block control: exponent latch, sample counter, completion strobe.
    always_comb begin
        take      = in_vd && !clr;
        blk_start = (cnt_q == '0);
        k_cur     = blk_start ? clamp_log2(dec_log2, MAX_LOG2) : k_lat_q;
        last_cnt  = (AD_CNT_NBIT'(1) << k_cur) - AD_CNT_NBIT'(1);
        acc_load  = take && blk_start;
        acc_add   = take && !blk_start;
        blk_done  = take && (cnt_q == last_cnt);

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = blk_done ? '0 : cnt_q + AD_CNT_NBIT'(1);
        end

        k_lat_d = k_lat_q;
        if (acc_load) begin
            k_lat_d = k_cur;
        end

        out_vd_d  = blk_done;
        blk_cnt_d = blk_cnt_q + AD_BLK_NBIT'(blk_done);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            k_lat_q   <= '0;
            out_vd_q  <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            k_lat_q   <= k_lat_d;
            out_vd_q  <= out_vd_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    for (genvar n = 0; n < CHN_NUM; n++) begin : g_lane
        ad_dec_lane #(
            .DATA_NBIT (DATA_NBIT),
            .MAX_LOG2  (MAX_LOG2)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .load  (acc_load),
            .add   (acc_add),
            .done  (blk_done),
            .k     (k_cur),
            .din   (in_data[n*DATA_NBIT +: DATA_NBIT]),
            .dout  (out_data[n*DATA_NBIT +: DATA_NBIT])
        );
    end

    assign out_vd  = out_vd_q;
    assign blk_cnt = blk_cnt_q;

endmodule
